// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending arbiter.
package irq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } fsm_t;

    localparam int unsigned N_DEFAULT      = 8;
    localparam int unsigned DROP_W_DEFAULT = 8;
    localparam int unsigned N_MAX          = 32;

    // Returns a mask as wide as the largest supported N; callers cast it to their own width.
    function automatic logic [N_MAX-1:0] onehot(input logic [4:0] idx);
        logic [N_MAX-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: bit 0 has the highest priority.
module lsb_priority_enc #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         vec,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ($clog2(N))'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending register with lowest-index selection and a valid/ready offer.
// Define IRQ_EDGE_DETECT_EN to pend on rising edges of req instead of on level.
module irq_pending_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned N      = N_DEFAULT,
    parameter int unsigned ID_W   = $clog2(N),
    parameter int unsigned DROP_W = DROP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [N-1:0]      req,
    input  logic [N-1:0]      mask,
    output logic              irq_valid,
    output logic [ID_W-1:0]   irq_id,
    input  logic              irq_ready,
    output logic [N-1:0]      pending,
    output logic [DROP_W-1:0] drop_cnt
);

    fsm_t              state_q, state_d;
    logic [N-1:0]      pending_q, pending_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [N-1:0]      set;
    logic [N-1:0]      clr;
    logic [N-1:0]      eligible;
    logic              elig_any;
    logic [ID_W-1:0]   elig_idx;
    logic              accept;
    logic              collide;

`ifdef IRQ_EDGE_DETECT_EN
    logic [N-1:0] req_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    assign set = req & ~req_q;
`else
    assign set = req;
`endif

    assign eligible = pending_q & mask;

    lsb_priority_enc #(
        .N (N)
    ) u_enc (
        .vec (eligible),
        .any (elig_any),
        .idx (elig_idx)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            irq_id_q  <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            irq_id_q  <= irq_id_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    // Next-state logic; the mask only matters when choosing a new offer.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            IDLE: begin
                if (elig_any) begin
                    state_d  = OFFER;
                    irq_id_d = elig_idx;
                end
            end
            OFFER: begin
                if (irq_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        irq_valid = (state_q == OFFER);
        accept    = irq_valid & irq_ready;
    end

    // Pending capture and drop counting; a set in the clear cycle keeps the bit pending.
    always_comb begin
        clr       = accept ? N'(onehot(5'(irq_id_q))) : '0;
        pending_d = (pending_q & ~clr) | set;
        collide   = |(set & pending_q & ~clr);
        drop_d    = drop_q;
        if (collide && (drop_q != '1)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    assign irq_id   = irq_id_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Directed bench for irq_pending_arbiter with an expected-index scoreboard.
module tb_irq_pending_arbiter;

    localparam int unsigned N      = 8;
    localparam int unsigned ID_W   = 3;
    localparam int unsigned DROP_W = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      req;
    logic [N-1:0]      mask;
    logic              irq_valid;
    logic [ID_W-1:0]   irq_id;
    logic              irq_ready;
    logic [N-1:0]      pending;
    logic [DROP_W-1:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    irq_pending_arbiter #(
        .N      (N),
        .DROP_W (DROP_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .mask      (mask),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ready (irq_ready),
        .pending   (pending),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for an offer and compares its index with the scoreboard head.
    task automatic pop_offer(input string tag);
        int w;
        int exp_id;
        w = 0;
        while (irq_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_valid"}, 32'(irq_valid), 1);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            exp_id = exp_q.pop_front();
            check({tag, "_id"}, 32'(irq_id), exp_id);
        end
    endtask

    task automatic do_reset();
        req       = '0;
        mask      = '1;
        irq_ready = 1'b0;
        resetn    = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // One collision on line 2, assuming pending[2] is already set.
    task automatic collide();
`ifdef IRQ_EDGE_DETECT_EN
        req = '0;
        @(negedge clk);
        req = 8'h04;
        @(negedge clk);
`else
        req = 8'h04;
        @(negedge clk);
`endif
    endtask

    initial begin
        resetn = 1'b1;
        #1;
        do_reset();

        // Reset values, then asynchronous reset during an offer
        check("rst_pending", 32'(pending), 0);
        check("rst_valid", 32'(irq_valid), 0);
        check("rst_id", 32'(irq_id), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        req = 8'h24;
        @(negedge clk);
        req = '0;
        @(negedge clk);
        check("pre_rst_valid", 32'(irq_valid), 1);
        check("pre_rst_pending", 32'(pending), 32'h24);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_pending", 32'(pending), 0);
        check("async_rst_valid", 32'(irq_valid), 0);
        check("async_rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", 32'(irq_valid), 0);
        check("post_rst_pending", 32'(pending), 0);

        // Priority: two lines from one pulse, lowest first, one bubble between
        do_reset();
        irq_ready = 1'b1;
        req = 8'h28;
        exp_q.push_back(3);
        exp_q.push_back(5);
        @(negedge clk);
        req = '0;
        check("prio_pending0", 32'(pending), 32'h28);
        check("prio_latency", 32'(irq_valid), 0);
        @(negedge clk);
        check("prio_valid_t2", 32'(irq_valid), 1);
        pop_offer("prio0");
        @(negedge clk);
        check("prio_bubble", 32'(irq_valid), 0);
        check("prio_pending1", 32'(pending), 32'h20);
        pop_offer("prio1");
        @(negedge clk);
        check("prio_pending2", 32'(pending), 0);
        check("prio_idle", 32'(irq_valid), 0);
        irq_ready = 1'b0;

        // Masking
        do_reset();
        mask = 8'hFB;
        req = 8'h06;
        exp_q.push_back(1);
        @(negedge clk);
        req = '0;
        pop_offer("mask0");
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
        check("mask_pending", 32'(pending), 32'h04);
        repeat (3) @(negedge clk);
        check("mask_no_offer", 32'(irq_valid), 0);
        check("mask_id_held", 32'(irq_id), 1);
        exp_q.push_back(2);
        mask = 8'hFF;
        pop_offer("mask1");
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
        check("mask_pending_end", 32'(pending), 0);

        // Stall: offer is held while a higher-priority line arrives and the mask drops it
        do_reset();
        req = 8'h10;
        exp_q.push_back(4);
        @(negedge clk);
        req = '0;
        pop_offer("stall0");
        req = 8'h01;
        mask = 8'hEF;
        @(negedge clk);
        req = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_id", 32'(irq_id), 4);
            check("stall_valid", 32'(irq_valid), 1);
        end
        check("stall_pending", 32'(pending), 32'h11);
        exp_q.push_back(0);
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
        check("stall_bubble", 32'(irq_valid), 0);
        check("stall_pending2", 32'(pending), 32'h01);
        pop_offer("stall1");
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
        check("stall_pending_end", 32'(pending), 0);
        mask = 8'hFF;

        // Collisions and saturation of the drop counter
        do_reset();
        req = 8'h04;
        @(negedge clk);
        check("coll_first_set", 32'(drop_cnt), 0);
        repeat (3) collide();
        check("coll_three", 32'(drop_cnt), 3);
        repeat (251) collide();
        check("coll_fe", 32'(drop_cnt), 32'hFE);
        collide();
        check("coll_sat", 32'(drop_cnt), 32'hFF);
        repeat (3) collide();
        check("coll_sat_hold", 32'(drop_cnt), 32'hFF);
        req = '0;

        // Set wins over clear on the accept cycle
        do_reset();
        req = 8'h40;
        exp_q.push_back(6);
        @(negedge clk);
        req = '0;
        pop_offer("svc0");
        irq_ready = 1'b1;
        req = 8'h40;
        @(negedge clk);
        irq_ready = 1'b0;
        req = '0;
        check("svc_pending", 32'(pending), 32'h40);
        check("svc_bubble", 32'(irq_valid), 0);
        exp_q.push_back(6);
        pop_offer("svc1");
        req = 8'h40;
        @(negedge clk);
        irq_ready = 1'b1;
        @(negedge clk);
        irq_ready = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
        check("held_pending", 32'(pending), 0);
        repeat (3) @(negedge clk);
        check("held_no_reoffer", 32'(irq_valid), 0);
        check("held_pending_end", 32'(pending), 0);
`else
        check("held_pending", 32'(pending), 32'h40);
        check("held_bubble", 32'(irq_valid), 0);
        exp_q.push_back(6);
        pop_offer("held_reoffer");
`endif
        req = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
